// File: rtl/fret_pos_loader.sv
// Fret position loader: shadow registers for five fret positions and a strum
// time, applied atomically to the active outputs on the next VSync after a
// Commit, or forced after TIMEOUT cycles of waiting.
// Optional build macro: POS_CLAMP_EN clamps written x to 1279 and y to 719.
module fret_pos_loader #(
  parameter logic [19:0] TIMEOUT = 20'hFFFFF
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        VSync,
  input  logic        WrEn,
  input  logic [2:0]  WrSel,
  input  logic [23:0] WrData,
  input  logic        Commit,
  output logic        WrReady,
  output logic [23:0] GreenPos,
  output logic [23:0] RedPos,
  output logic [23:0] YellowPos,
  output logic [23:0] BluePos,
  output logic [23:0] OrangePos,
  output logic [3:0]  StrumTime,
  output logic        Applied,
  output logic        TimedOut
);

  typedef enum logic [1:0] {StIdle, StPend, StApply} state_e;

  state_e      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic        timed_out_q, timed_out_d;
  logic        applied_q;
  logic        accept_wr;
  logic        load;

  logic [23:0] shadow_pos_q [5];
  logic [23:0] active_pos_q [5];
  logic [3:0]  shadow_strum_q;
  logic [3:0]  active_strum_q;

  logic [10:0] wr_x;
  logic [9:0]  wr_y;
  logic [23:0] wr_pos;

  // Padding bits of a position write are never stored.
  logic unused_wr;
  assign unused_wr = ^{WrData[23:22], WrData[11]};

  // Format a position write: zero the padding bits, optionally clamp x/y.
  always_comb begin
    wr_x = WrData[10:0];
    wr_y = WrData[21:12];
`ifdef POS_CLAMP_EN
    if (wr_x > 11'd1279) wr_x = 11'd1279;
    if (wr_y > 10'd719)  wr_y = 10'd719;
`endif
    wr_pos = {2'b00, wr_y, 1'b0, wr_x};
  end

  // Next-state logic: commit handshake, VSync/timeout wait, one-cycle apply.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    timed_out_d = timed_out_q;
    accept_wr   = 1'b0;
    load        = 1'b0;
    unique case (state_q)
      StIdle: begin
        accept_wr = WrEn;
        if (Commit) begin
          state_d = StPend;
          cnt_d   = '0;
        end
      end
      StPend: begin
        if (cnt_q != 20'hFFFFF) cnt_d = cnt_q + 20'd1;
        // VSync wins over a timeout landing on the same edge.
        if (VSync) begin
          state_d     = StApply;
          timed_out_d = 1'b0;
        end else if (({1'b0, cnt_q} + 21'd1) >= {1'b0, TIMEOUT}) begin
          state_d     = StApply;
          timed_out_d = 1'b1;
        end
      end
      StApply: begin
        load    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      timed_out_q <= 1'b0;
      applied_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      timed_out_q <= timed_out_d;
      applied_q   <= load;
    end
  end

  // Shadow writes (IDLE only) and atomic shadow-to-active transfer on APPLY.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 5; i++) begin
        shadow_pos_q[i] <= '0;
        active_pos_q[i] <= '0;
      end
      shadow_strum_q <= '0;
      active_strum_q <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (accept_wr && (WrSel == 3'(i))) shadow_pos_q[i] <= wr_pos;
        if (load) active_pos_q[i] <= shadow_pos_q[i];
      end
      if (accept_wr && (WrSel == 3'd5)) shadow_strum_q <= WrData[3:0];
      if (load) active_strum_q <= shadow_strum_q;
    end
  end

  assign WrReady   = (state_q == StIdle);
  assign GreenPos  = active_pos_q[0];
  assign RedPos    = active_pos_q[1];
  assign YellowPos = active_pos_q[2];
  assign BluePos   = active_pos_q[3];
  assign OrangePos = active_pos_q[4];
  assign StrumTime = active_strum_q;
  assign Applied   = applied_q;
  assign TimedOut  = timed_out_q;

endmodule

// File: tb/tb_fret_pos_loader.sv
// Directed testbench for fret_pos_loader (TIMEOUT overridden to 16).
module tb_fret_pos_loader;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        VSync = 1'b0;
  logic        WrEn = 1'b0;
  logic [2:0]  WrSel = 3'd0;
  logic [23:0] WrData = 24'd0;
  logic        Commit = 1'b0;
  logic        WrReady;
  logic [23:0] GreenPos, RedPos, YellowPos, BluePos, OrangePos;
  logic [3:0]  StrumTime;
  logic        Applied;
  logic        TimedOut;

  int checks = 0;
  int errors = 0;
  int n;

`ifdef POS_CLAMP_EN
  localparam logic [23:0] ClampExp = 24'h2CF4FF;
`else
  localparam logic [23:0] ClampExp = 24'h3FF7FF;
`endif

  fret_pos_loader #(.TIMEOUT(20'd16)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .VSync     (VSync),
    .WrEn      (WrEn),
    .WrSel     (WrSel),
    .WrData    (WrData),
    .Commit    (Commit),
    .WrReady   (WrReady),
    .GreenPos  (GreenPos),
    .RedPos    (RedPos),
    .YellowPos (YellowPos),
    .BluePos   (BluePos),
    .OrangePos (OrangePos),
    .StrumTime (StrumTime),
    .Applied   (Applied),
    .TimedOut  (TimedOut)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset
    #2;
    check("rst_wrready", 24'(WrReady), 24'd1);
    check("rst_green", GreenPos, 24'd0);
    check("rst_applied", 24'(Applied), 24'd0);
    check("rst_timedout", 24'(TimedOut), 24'd0);
    step();
    RST_N = 1'b1;
    step();

    // Green write, commit, VSync 10 cycles later
    WrEn = 1'b1; WrSel = 3'd0; WrData = 24'h0C81F4;
    step();
    WrEn = 1'b0; Commit = 1'b1;
    step();
    Commit = 1'b0;
    check("t1_pend_wrready", 24'(WrReady), 24'd0);
    repeat (9) step();
    VSync = 1'b1;
    step();                              // edge t: PEND -> APPLY
    VSync = 1'b0;
    check("t1_apply_green_old", GreenPos, 24'd0);
    check("t1_apply_applied", 24'(Applied), 24'd0);
    step();                              // edge t+1: actives loaded, seen at t+2
    check("t1_green", GreenPos, 24'h0C81F4);
    check("t1_applied", 24'(Applied), 24'd1);
    check("t1_wrready", 24'(WrReady), 24'd1);
    check("t1_red", RedPos, 24'd0);
    check("t1_orange", OrangePos, 24'd0);
    check("t1_strum", 24'(StrumTime), 24'd0);
    step();
    check("t1_applied_drop", 24'(Applied), 24'd0);

    // Writes in PEND are ignored
    Commit = 1'b1;
    step();
    Commit = 1'b0;
    WrEn = 1'b1; WrSel = 3'd1; WrData = 24'h123456;
    step();
    WrEn = 1'b0;
    check("t2_pend_wrready", 24'(WrReady), 24'd0);
    step();
    check("t2_pend_wrready2", 24'(WrReady), 24'd0);
    VSync = 1'b1;
    step();
    VSync = 1'b0;
    step();
    check("t2_applied", 24'(Applied), 24'd1);
    check("t2_red", RedPos, 24'd0);
    check("t2_green", GreenPos, 24'h0C81F4);
    check("t2_timedout", 24'(TimedOut), 24'd0);
    step();

    // Timeout: 16 PEND cycles then forced apply
    Commit = 1'b1;
    step();
    Commit = 1'b0;
    n = 0;
    while (Applied !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check("t3_timeout_cycles", 24'(n), 24'd17);
    check("t3_timedout", 24'(TimedOut), 24'd1);
    step();
    check("t3_timedout_sticky", 24'(TimedOut), 24'd1);
    Commit = 1'b1;
    step();
    Commit = 1'b0;
    VSync = 1'b1;
    step();
    VSync = 1'b0;
    step();
    check("t3_vsync_applied", 24'(Applied), 24'd1);
    check("t3_timedout_clr", 24'(TimedOut), 24'd0);
    step();

    // Commit and VSync in the same cycle; only the later VSync applies
    Commit = 1'b1; VSync = 1'b1;
    step();
    Commit = 1'b0; VSync = 1'b0;
    n = 0;
    repeat (4) begin
      step();
      if (Applied !== 1'b0) n++;
    end
    check("t4_no_early_apply", 24'(n), 24'd0);
    check("t4_pend_wrready", 24'(WrReady), 24'd0);
    VSync = 1'b1;
    step();
    VSync = 1'b0;
    check("t4_apply_not_yet", 24'(Applied), 24'd0);
    step();
    check("t4_applied", 24'(Applied), 24'd1);
    step();

    // Masking, clamping, strum, write+commit in the same cycle
    WrEn = 1'b1; WrSel = 3'd4; WrData = 24'h3FF7FF;
    step();
    WrSel = 3'd2; WrData = 24'hFFFFFF;
    step();
    WrSel = 3'd5; WrData = 24'hABCDE7;
    step();
    WrSel = 3'd6; WrData = 24'h0AAAAA;
    step();
    WrSel = 3'd3; WrData = 24'h100200; Commit = 1'b1;
    step();
    WrEn = 1'b0; Commit = 1'b0;
    step();
    VSync = 1'b1;
    step();
    VSync = 1'b0;
    step();
    check("t5_orange", OrangePos, ClampExp);
    check("t5_yellow_mask", YellowPos, ClampExp);
    check("t5_strum", 24'(StrumTime), 24'h7);
    check("t5_blue_same_cycle", BluePos, 24'h100200);
    check("t5_green_keep", GreenPos, 24'h0C81F4);
    step();

    // Reset during APPLY aborts the transfer
    WrEn = 1'b1; WrSel = 3'd1; WrData = 24'h000055;
    step();
    WrEn = 1'b0; Commit = 1'b1;
    step();
    Commit = 1'b0; VSync = 1'b1;
    step();                              // now in APPLY
    VSync = 1'b0;
    #2;
    RST_N = 1'b0;
    #1;
    check("t6_rst_green", GreenPos, 24'd0);
    check("t6_rst_orange", OrangePos, 24'd0);
    check("t6_rst_strum", 24'(StrumTime), 24'd0);
    check("t6_rst_applied", 24'(Applied), 24'd0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    step();
    check("t6_post_applied", 24'(Applied), 24'd0);
    check("t6_post_wrready", 24'(WrReady), 24'd1);
    check("t6_post_red", RedPos, 24'd0);
    step();
    check("t6_post_applied2", 24'(Applied), 24'd0);
    // Shadows were cleared too: a fresh apply yields zeros
    Commit = 1'b1;
    step();
    Commit = 1'b0; VSync = 1'b1;
    step();
    VSync = 1'b0;
    step();
    check("t6_reapply_applied", 24'(Applied), 24'd1);
    check("t6_reapply_red", RedPos, 24'd0);
    check("t6_reapply_blue", BluePos, 24'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
